freq_meas: RTL and testbench

Measures a slow square-wave input against the reference clock and reports its high time, low time, full period and recovered divide factor in reference-clock cycles. It is the measurement counterpart of the team's clock divider: feeding a divider output, with the divider's input clock equal to `Clk_Ref`, into `Sig_In` returns the programmed divide factor on `Div_Est`. It sits in the lab/debug path, is synchronous to `Clk_Ref`, and treats `Sig_In` as asynchronous data.

---
 rtl/freq_meas.sv | 107 ++++++++++
 tb/tb_freq_meas.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meas.sv
// Measures high time, low time and period of a slow asynchronous square
// wave in Clk_Ref cycles and recovers the divide factor that produced it.
module freq_meas #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000
) (
    input  logic             Clk_Ref,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             Sig_In,
    output logic [WIDTH-1:0] High_Cnt,
    output logic [WIDTH-1:0] Low_Cnt,
    output logic [WIDTH:0]   Period,
    output logic [WIDTH-1:0] Div_Est,
    output logic             Valid,
    output logic             Timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ARM_LOW,
        ARM_RISE,
        HIGH,
        LOW
    } state_t;

    localparam logic [WIDTH-1:0] TO_CNT = WIDTH'(TIMEOUT_CYC);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t           state;
    logic             s1, s2, s3;
    logic [WIDTH-1:0] cnt;
    logic             rise, fall;
    logic [WIDTH:0]   sum;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
    // High_Cnt already holds the high phase closed by the preceding fall.
    assign sum  = {1'b0, High_Cnt} + {1'b0, cnt};

    always_ff @(posedge Clk_Ref) begin
        if (!Rst_n) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            cnt      <= '0;
            High_Cnt <= '0;
            Low_Cnt  <= '0;
            Period   <= '0;
            Div_Est  <= '0;
            Valid    <= 1'b0;
            Timeout  <= 1'b0;
        end else begin
            s1    <= Sig_In;
            s2    <= s1;
            s3    <= s2;
            Valid <= 1'b0;
            if (!En) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: state <= ARM_LOW;
                    ARM_LOW: begin
                        if (!s2) state <= ARM_RISE;
                    end
                    ARM_RISE: begin
                        if (rise) begin
                            cnt   <= ONE;
                            state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            High_Cnt <= cnt;
                            cnt      <= ONE;
                            state    <= LOW;
                        end else if (cnt == TO_CNT) begin
                            Timeout <= 1'b1;
                            state   <= ARM_LOW;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            Low_Cnt <= cnt;
                            Period  <= sum;
                            Div_Est <= sum[WIDTH:1];
                            Valid   <= 1'b1;
                            Timeout <= 1'b0;
                            cnt     <= ONE;
                            state   <= HIGH;
                        end else if (cnt == TO_CNT) begin
                            Timeout <= 1'b1;
                            state   <= ARM_LOW;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_meas.sv
// Scoreboard bench for freq_meas: one instance with a 20-cycle timeout,
// one with a 6-cycle timeout for the edge/timeout coincidence cases.
module tb_freq_meas;

    typedef struct {
        int h;
        int l;
        int p;
        int d;
        int gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, sig_a, en_b, sig_b;
    logic [31:0] high_a, low_a, div_a, high_b, low_b, div_b;
    logic [32:0] per_a, per_b;
    logic        valid_a, tmo_a, valid_b, tmo_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_a = 0;
    int   last_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    freq_meas #(.WIDTH(32), .TIMEOUT_CYC(32'd20)) dut_a (
        .Clk_Ref (clk),
        .Rst_n   (rst_n),
        .En      (en_a),
        .Sig_In  (sig_a),
        .High_Cnt(high_a),
        .Low_Cnt (low_a),
        .Period  (per_a),
        .Div_Est (div_a),
        .Valid   (valid_a),
        .Timeout (tmo_a)
    );

    freq_meas #(.WIDTH(32), .TIMEOUT_CYC(32'd6)) dut_b (
        .Clk_Ref (clk),
        .Rst_n   (rst_n),
        .En      (en_b),
        .Sig_In  (sig_b),
        .High_Cnt(high_b),
        .Low_Cnt (low_b),
        .Period  (per_b),
        .Div_Est (div_b),
        .Valid   (valid_b),
        .Timeout (tmo_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_high", high_a, ea.h);
                chk("a_low", low_a, ea.l);
                chk("a_period", per_a, ea.p);
                chk("a_div", div_a, ea.d);
                chk("a_timeout_clr", tmo_a, 0);
                if (ea.gap != 0) chk("a_gap", cyc - last_a, ea.gap);
            end
            last_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_high", high_b, eb.h);
                chk("b_low", low_b, eb.l);
                chk("b_period", per_b, eb.p);
                chk("b_div", div_b, eb.d);
                chk("b_timeout_clr", tmo_b, 0);
                if (eb.gap != 0) chk("b_gap", cyc - last_b, eb.gap);
            end
            last_b = cyc;
        end
    end

    task automatic set_sig(input bit sel, input logic v);
        if (sel) sig_b = v;
        else sig_a = v;
    endtask

    task automatic set_en(input bit sel, input logic v);
        if (sel) en_b = v;
        else en_a = v;
    endtask

    task automatic push(input bit sel, input int h, input int l,
                        input int p, input int d, input int gap);
        exp_t e;
        e.h   = h;
        e.l   = l;
        e.p   = p;
        e.d   = d;
        e.gap = gap;
        if (sel) qb.push_back(e);
        else qa.push_back(e);
    endtask

    // n full periods plus a closing high phase, so n results are expected.
    task automatic wave(input bit sel, input int h, input int l,
                        input int n, input int p, input int d);
        for (int i = 0; i < n; i++)
            push(sel, h, l, p, d, (i == 0) ? 0 : h + l);
        for (int i = 0; i < n; i++) begin
            set_sig(sel, 1'b1);
            repeat (h) @(negedge clk);
            set_sig(sel, 1'b0);
            repeat (l) @(negedge clk);
        end
        set_sig(sel, 1'b1);
        repeat (h) @(negedge clk);
        set_sig(sel, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic sec_start(input bit sel);
        set_en(sel, 1'b0);
        set_sig(sel, 1'b0);
        repeat (3) @(negedge clk);
        set_en(sel, 1'b1);
        repeat (5) @(negedge clk);
    endtask

    task automatic sec_stop(input bit sel);
        set_en(sel, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_high"}, high_a, 0);
        chk({tag, "_low"}, low_a, 0);
        chk({tag, "_period"}, per_a, 0);
        chk({tag, "_div"}, div_a, 0);
        chk({tag, "_valid"}, valid_a, 0);
        chk({tag, "_timeout"}, tmo_a, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b0;
        sig_a = 1'b0;
        en_b  = 1'b0;
        sig_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_a("rst");
        rst_n = 1'b1;
        @(negedge clk);

        sec_start(0);
        wave(0, 5, 5, 3, 10, 5);
        sec_stop(0);

        sec_start(0);
        wave(0, 3, 8, 2, 11, 5);
        sec_stop(0);

        sec_start(0);
        wave(0, 1, 2, 3, 3, 1);
        sec_stop(0);

        // Disable while in LOW: no result, outputs hold, then full re-arm.
        sec_start(0);
        wave(0, 5, 5, 1, 10, 5);
        en_a = 1'b0;
        sig_a = 1'b1;
        repeat (3) @(negedge clk);
        sig_a = 1'b0;
        repeat (3) @(negedge clk);
        sig_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("dis_hold_high", high_a, 5);
        chk("dis_hold_period", per_a, 10);
        sig_a = 1'b0;
        repeat (4) @(negedge clk);
        en_a = 1'b1;
        repeat (5) @(negedge clk);
        wave(0, 2, 6, 1, 8, 4);
        sec_stop(0);

        // Stuck high: timeout 20 cycles after the rise is processed.
        sec_start(0);
        sig_a = 1'b1;
        repeat (22) @(negedge clk);
        chk("tmo_before", tmo_a, 0);
        @(negedge clk);
        chk("tmo_set", tmo_a, 1);
        chk("tmo_hold_period", per_a, 8);
        repeat (5) @(negedge clk);
        chk("tmo_sticky", tmo_a, 1);
        sig_a = 1'b0;
        repeat (4) @(negedge clk);
        wave(0, 4, 4, 1, 8, 4);
        chk("tmo_cleared", tmo_a, 0);
        sec_stop(0);

        // Reset mid-HIGH, then start-high rejection of the partial phase.
        sec_start(0);
        sig_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        en_a  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero_a("midrst");
        repeat (5) @(negedge clk);
        en_a = 1'b1;
        repeat (6) @(negedge clk);
        sig_a = 1'b0;
        repeat (4) @(negedge clk);
        wave(0, 3, 5, 1, 8, 4);
        sec_stop(0);

        // Phases of exactly TIMEOUT_CYC: the edge wins over the timeout.
        sec_start(1);
        wave(1, 3, 6, 2, 9, 4);
        sec_stop(1);
        sec_start(1);
        wave(1, 6, 6, 2, 12, 6);
        chk("b_tmo_edge_wins", tmo_b, 0);
        repeat (8) @(negedge clk);
        chk("b_tmo_long_low", tmo_b, 1);
        sec_stop(1);

        for (int i = 0; i < 50 && (qa.size() != 0 || qb.size() != 0); i++)
            @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
